fifo_rd_packer: RTL
===================

// Module: fifo_rd_packer
// PURPOSE
//  Read-side drain stage for the async FIFO, running in the FIFO read clock domain.
//  Pops WIDTH-bit words from the FIFO read port and packs RATIO consecutive words into
//  one OW-bit output beat. Output uses a valid/ready handshake.
//  A flush request emits any partial beat with a lane mask and a last marker.
// PARAMETERS
//  WIDTH  8            FIFO word width
//  RATIO  4            words per output beat (>=2)
//  OW     WIDTH*RATIO  output beat width (derived; do not override)
// PORTS
//  clk          in   1      read-domain clock, single clock for whole block
//  rst          in   1      synchronous, active-high reset
//  fifo_empty   in   1      FIFO empty flag
//  fifo_rdata   in   WIDTH  FIFO read data, valid the cycle after an accepted pop
//  fifo_rd_en   out  1      pop request to FIFO (combinational)
//  flush        in   1      1-cycle pulse: emit partial beat
//  out_valid    out  1      output beat valid
//  out_ready    in   1      downstream accepts beat
//  out_data     out  OW     packed beat, lane 0 = first word = out_data[WIDTH-1:0]
//  out_keep     out  RATIO  lane-valid mask
//  out_last     out  1      beat produced by flush
//  beat_cnt     out  16     count of beats accepted (out_valid&&out_ready), wraps at 2^16
// BEHAVIOUR
//  Reset: out_valid, out_data, out_keep, out_last and beat_cnt are all 0.
//   Internal state is cleared: acc_cnt=0, pend=0, flush_req=0.
//   A pop in flight at reset is discarded. fifo_rd_en=0 while rst=1.
//  pend: registered (fifo_rd_en && !fifo_empty). When pend=1, fifo_rdata is written to
//   lane acc_cnt and acc_cnt increments. The acc_cnt range is 0..RATIO.
//  fifo_rd_en = !rst && !fifo_empty && !flush_req && (acc_cnt + pend < RATIO).
//   The block never pops on empty and never overruns the accumulator.
//  Move: when acc_cnt==RATIO and (!out_valid || out_ready), do all of the following:
//   load out_data with the accumulator, out_keep all ones, out_last=0, out_valid=1,
//   and set acc_cnt=0. pend is guaranteed 0 in this cycle.
//  Handshake: while out_valid && !out_ready, out_data, out_keep and out_last stay stable.
//   out_valid drops the cycle after acceptance unless a new move or flush loads the
//   output in that same cycle.
//  Throughput: continuous data with out_ready=1 gives one beat every RATIO+2 cycles
//   (6 cycles at RATIO=4).
//  Flush: the flush pulse sets flush_req, which blocks new pops. A pop already pending
//   still lands in the accumulator. When pend==0 and the output is free:
//    - acc_cnt>0: load the beat with out_keep=(1<<acc_cnt)-1, unfilled lanes 0,
//      out_last=1. Then clear acc_cnt and flush_req.
//    - acc_cnt==0: clear flush_req, no beat is emitted.
//   Flush takes priority over a normal move. A full accumulator under flush is emitted
//   with out_last=1.
//   A flush pulse while flush_req=1 is absorbed (no second beat).
//  beat_cnt increments on each accepted beat. 16'hFFFF wraps to 0.
//  Upstream FIFO full, and wr_err/rd_err, are not observed here. This block must never
//   provoke rd_err.
// TESTING
//  1 Reset, then 8 words 11..88 in FIFO, out_ready=1 -> beats 0x44332211 then 0x88776655,
//    keep 4'hF, last=0, beat_cnt=2, fifo_rd_en never high while fifo_empty=1.
//  2 12 words queued, out_ready=0 for 30 cycles -> beat1 held stable, exactly 8 pops
//    then fifo_rd_en=0. Release ready -> beats 2 and 3 follow in order.
//  3 Words A1,A2,A3 then flush -> out_data=0x00A3A2A1, keep=4'b0111, last=1.
//    The following 4 words form a normal full beat.
//  4 Flush in the same cycle a pop is accepted (pend lands next cycle) -> that word is
//    included in the flush beat. Flush with empty accumulator -> no beat, beat_cnt
//    unchanged.
//  5 rst asserted with acc_cnt=2 and out_valid=1 -> next cycle out_valid=0, beat_cnt=0.
//    The pending word is dropped and the first beat after reset holds only new words.
//  6 Continuous supply, out_ready=1, 40 words -> 10 beats, spacing exactly 6 cycles,
//    beat_cnt=10.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-side drain stage: pops FIFO words and packs RATIO of them into one output beat,
// with a flush path that emits a partial beat carrying a lane mask and a last marker.
module fifo_rd_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4,
    parameter int OW    = WIDTH * RATIO
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_rdata,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_data,
    output logic [RATIO-1:0] out_keep,
    output logic             out_last,
    output logic [15:0]      beat_cnt
);

    localparam int ACW = $clog2(RATIO + 1);
    localparam logic [ACW-1:0] FULL = ACW'(RATIO);

    logic [ACW-1:0]   acc_cnt_q, acc_cnt_d;
    logic             pend_q;
    logic             flush_req_q, flush_req_d;
    logic [WIDTH-1:0] acc_q [RATIO];

    logic             out_valid_q, out_valid_d;
    logic [OW-1:0]    out_data_q, out_data_d;
    logic [RATIO-1:0] out_keep_q, out_keep_d;
    logic             out_last_q, out_last_d;
    logic [15:0]      beat_cnt_q;

    logic [ACW:0]     fill_level;
    logic             out_free;
    logic             accept;
    logic             flush_fire;
    logic             flush_emit;
    logic             move;
    logic             load;
    logic [RATIO-1:0] lane_keep;
    logic [OW-1:0]    packed_data;

    // Words already popped but not yet landed count against accumulator space.
    assign fill_level = {1'b0, acc_cnt_q} + {{ACW{1'b0}}, pend_q};
    assign fifo_rd_en = !rst && !fifo_empty && !flush_req_q && (fill_level < {1'b0, FULL});

    assign out_free   = !out_valid_q || out_ready;
    assign accept     = out_valid_q && out_ready;
    assign flush_fire = flush_req_q && !pend_q && out_free;
    assign flush_emit = flush_fire && (acc_cnt_q != '0);
    assign move       = !flush_fire && (acc_cnt_q == FULL) && out_free;
    assign load       = flush_emit || move;

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            assign lane_keep[gi] = (ACW'(gi) < acc_cnt_q);
            // Unfilled lanes may hold stale words from an earlier beat, so mask them.
            assign packed_data[gi*WIDTH +: WIDTH] = lane_keep[gi] ? acc_q[gi] : '0;

            always_ff @(posedge clk) begin
                if (!rst && pend_q && (acc_cnt_q == ACW'(gi))) begin
                    acc_q[gi] <= fifo_rdata;
                end
            end
        end
    endgenerate

    always_comb begin
        acc_cnt_d   = acc_cnt_q;
        flush_req_d = flush_req_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;

        if (pend_q) begin
            acc_cnt_d = acc_cnt_q + ACW'(1);
        end
        if (flush_fire || move) begin
            acc_cnt_d = '0;
        end

        // A pulse arriving while a flush is outstanding is absorbed.
        if (flush_fire) begin
            flush_req_d = 1'b0;
        end else if (flush) begin
            flush_req_d = 1'b1;
        end

        if (accept) begin
            out_valid_d = 1'b0;
        end
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = packed_data;
            out_keep_d  = lane_keep;
            out_last_d  = flush_emit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt_q   <= '0;
            pend_q      <= 1'b0;
            flush_req_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            acc_cnt_q   <= acc_cnt_d;
            pend_q      <= fifo_rd_en;
            flush_req_q <= flush_req_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            beat_cnt_q  <= beat_cnt_q + 16'(accept);
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;
    assign out_last  = out_last_q;
    assign beat_cnt  = beat_cnt_q;

endmodule
